// File: rtl/fifo_umbral.sv
// fifo_umbral -- synchronous data FIFO with programmable almost-full /
// almost-empty thresholds ("umbrales"). One instance per lane, sitting
// between the data source and the controller-gated sink. The status outputs
// feed the downstream idle/active/error/init control state machine.
//
// Optional feature macro: ERR_STICKY_EN
//   defined   : error_out latches on the first overflow/underflow and holds
//               until reset is asserted.
//   undefined : error_out is a one-cycle registered pulse per event cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   push/data_in write request and write data
//   pop          read request
//   umbral_alto  almost-full threshold  (almost_full  = count >= umbral_alto)
//   umbral_bajo  almost-empty threshold (almost_empty = count <= umbral_bajo)
//   data_out     registered read data, valid_out pulses once per accepted pop
//   fifo_full    count == DEPTH
//   fifo_empty   count == 0
//   fifo_write   accepted write on the previous cycle
//   fifo_read    accepted read on the previous cycle
//   error_out    overflow/underflow indication
//   count        current occupancy (0..DEPTH)
module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [CNT_W-1:0]  umbral_alto,
  input  logic [CNT_W-1:0]  umbral_bajo,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_write,
  output logic              fifo_read,
  output logic              error_out,
  output logic [CNT_W-1:0]  count
);

  localparam int DEPTH_INT = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(DEPTH_INT);

  logic [DATA_W-1:0] mem [DEPTH_INT];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic rd_ok;
  logic wr_ok;
  logic err_event;

  // Status flags come straight from the registered count.
  assign fifo_full    = (count == DEPTH);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= umbral_alto);
  assign almost_empty = (count <= umbral_bajo);

  // A push into a full FIFO is still accepted when a pop frees a slot on the
  // same edge. A pop on an empty FIFO is never bypassed from data_in.
  assign rd_ok     = pop & ~fifo_empty;
  assign wr_ok     = push & (~fifo_full | pop);
  assign err_event = (push & fifo_full & ~pop) | (pop & fifo_empty);

  // Storage has no reset: contents are don't-care after reset, which keeps
  // the array mappable to distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_write <= 1'b0;
      fifo_read  <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      fifo_write <= wr_ok;
      fifo_read  <= rd_ok;
      valid_out  <= rd_ok;

      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;  // natural rollover gives modulo DEPTH
      end

      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end

      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end

`ifdef ERR_STICKY_EN
      error_out <= error_out | err_event;
`else
      error_out <= err_event;
`endif
    end
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
Synchronous data FIFO with programmable almost-full/almost-empty thresholds ("umbrales").
Generates the FifoFull/FifoEmpty/FifoRead/FifoWrite status that feeds the control state machine (idle/active/error/init) directly downstream.
Also flags overflow/underflow so the controller can enter ERROR.
One per lane; sits between the data source and the controller-gated sink.

Parameters:
DATA_W, 6, width of each data word
ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
CNT_W, ADDR_W+1, occupancy counter width (0..DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately when 0
push  input  1  write request
data_in  input  DATA_W  write data, sampled with push
pop  input  1  read request
umbral_alto  input  CNT_W  almost-full threshold
umbral_bajo  input  CNT_W  almost-empty threshold
data_out  output  DATA_W  read data, registered
valid_out  output  1  data_out valid, one-cycle pulse per accepted pop
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= umbral_alto
almost_empty  output  1  count <= umbral_bajo
fifo_write  output  1  registered: write accepted previous cycle
fifo_read  output  1  registered: read accepted previous cycle
error_out  output  1  overflow/underflow indication
count  output  CNT_W  current occupancy

Behaviour:
- Reset (reset=0, async):
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, valid_out = 0, fifo_write = fifo_read = 0, error_out = 0.
  - Memory contents are don't-care.
  - Flags derive from count, so fifo_empty = 1, fifo_full = 0.
  - Reset asserted mid-operation discards all stored words; there is no partial recovery.
- Accept rules, evaluated on the same edge:
  - rd_ok = pop & ~fifo_empty
  - wr_ok = push & (~fifo_full | pop)
  - Push while full with simultaneous pop: both accepted, count unchanged.
  - Pop while empty with simultaneous push: pop rejected (no bypass), push accepted.
- Write: mem[wr_ptr] <= data_in; wr_ptr wraps modulo DEPTH (natural ADDR_W rollover).
- Read: data_out <= mem[rd_ptr] and valid_out <= 1 on the next edge, so latency is 1 cycle from pop. rd_ptr wraps modulo DEPTH.
  - On cycles with no accepted read, data_out holds its value and valid_out = 0.
- Occupancy count:
  - +1 if wr_ok & ~rd_ok
  - -1 if rd_ok & ~wr_ok
  - otherwise unchanged
  - Never exceeds DEPTH and never underflows.
- Flags: fifo_full, fifo_empty, almost_full and almost_empty are combinational from the registered count (no extra latency after the count update).
  - Thresholds are unsigned compares.
  - umbral_alto = 0 gives almost_full = 1 always.
  - umbral_bajo >= DEPTH gives almost_empty = 1 always.
  - Thresholds may change at any time and take effect immediately.
- fifo_write / fifo_read: registered copies of wr_ok / rd_ok.
- Error events:
  - overflow = push & fifo_full & ~pop
  - underflow = pop & fifo_empty
  - error_out behaviour on these events is set by ERR_STICKY_EN (see Optional Feature).
  - Rejected operations change no pointer, count or memory.

Optional Feature:
Macro ERR_STICKY_EN.
- Defined: error_out is set on the edge after the first overflow/underflow and held at 1 until reset = 0.
- Undefined: error_out is a registered one-cycle pulse for each cycle in which overflow or underflow occurred; it returns to 0 the following cycle when no event is present.

Test Plan:
1. Reset, then DEPTH=4, umbral_alto=3, umbral_bajo=1; push 0x11, 0x22, 0x33, 0x04 on 4 cycles.
   -> count 1,2,3,4; almost_full rises at count=3; fifo_full=1 at count 4; error_out=0.
2. From full, push 0x3F without pop.
   -> count stays 4, memory unchanged, error_out=1 next cycle (sticky if ERR_STICKY_EN, else 1-cycle pulse).
3. Pop 4 times.
   -> data_out 0x11, 0x22, 0x33, 0x04 each 1 cycle after its pop with valid_out=1; fifo_empty=1 after the 4th; almost_empty=1 at count<=1.
4. Empty FIFO: pop + push 0x2A same cycle.
   -> pop rejected, valid_out=0, error_out asserted, count=1; next pop returns 0x2A.
5. Full FIFO: push 0x15 + pop same cycle.
   -> both accepted, count stays 4, oldest word out; after 6 further writes/reads the pointers wrap and FIFO order is preserved.
6. Reset driven to 0 asynchronously with count=3 (between clock edges).
   -> immediately count=0, fifo_empty=1, valid_out=0, error_out=0; after release, first push/pop behaves as from fresh state.
